// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath: sequences fetch,
// decode, execute, memory and writeback, and drives every datapath enable.
//
// Ports:
//   clk, reset (async, active-low)
//   OP (opcode, sampled in DECODE), zero (ALU zero flag, used in BRANCH)
//   PCWrite IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite
//   ALUSrcA ALUSrcB PCSource ALUOp   datapath controls
//   state_o (debug), illegal (sticky unsupported-opcode flag)
//
// Parameters: MEM_LATENCY (1..15 cycles per memory access), ALUOP_W.
// Build option: define MULTICYCLE_JAL_EN to decode OP 0x03 as JAL;
// without it 0x03 is treated as an illegal opcode.
module multicycle_control #(
  parameter int MEM_LATENCY = 1,
  parameter int ALUOP_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic               zero,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state_o,
  output logic               illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_WB_I     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(3'b111);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  logic [3:0] state;
  logic [3:0] state_n;
  logic [3:0] cnt;
  logic [5:0] op_q;
  logic       last;

  logic is_r;
  logic is_i;
  logic is_mem;
  logic is_br;
  logic is_j;
  logic is_jal;
  logic legal;

  assign is_r   = (OP == OP_R);
  assign is_i   = (OP == OP_ADDI) || (OP == OP_ORI)
               || (OP == OP_ANDI);
  assign is_mem = (OP == OP_LW) || (OP == OP_SW);
  assign is_br  = (OP == OP_BEQ) || (OP == OP_BNE);
  assign is_j   = (OP == OP_J);
`ifdef MULTICYCLE_JAL_EN
  assign is_jal = (OP == OP_JAL);
`else
  assign is_jal = 1'b0;
`endif
  assign legal  = is_r | is_i | is_mem | is_br | is_j | is_jal;

  // Final cycle of a memory-holding state.
  assign last = (cnt == 4'd0);

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH: begin
        if (last) state_n = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_n = S_EXEC_R;
          is_i:    state_n = S_EXEC_I;
          is_mem:  state_n = S_MEM_ADDR;
          is_br:   state_n = S_BRANCH;
          is_j:    state_n = S_JUMP;
          is_jal:  state_n = S_JAL;
          default: state_n = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        state_n = (op_q == OP_LW) ? S_MEM_RD
                                  : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (last) state_n = S_MEM_WB;
      end
      S_MEM_WR: begin
        if (last) state_n = S_FETCH;
      end
      S_EXEC_R: state_n = S_WB_R;
      S_EXEC_I: state_n = S_WB_I;
      default:  state_n = S_FETCH;
    endcase
  end

  // The counter reloads on every state change, so it is always
  // fresh on entry to a memory state; only those states ever stay put.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      cnt     <= LAT_M1;
      op_q    <= 6'h00;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        cnt <= LAT_M1;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == S_DECODE) begin
        op_q <= OP;
        if (!legal) illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ALUOp    = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = last;
        PCWrite = last;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_R;
      end
      S_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (op_q == OP_ORI) begin
          ALUOp = ALU_OR;
        end else if (op_q == OP_ANDI) begin
          ALUOp = ALU_AND;
        end else begin
          ALUOp = ALU_ADD;
        end
      end
      S_WB_I: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        PCWrite  = (op_q == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      // PC already holds PC+4 here; the datapath routes it to r31.
      S_JAL: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      // Reserved: no decode path leads here.
      S_JR: begin
        ALUSrcA  = 1'b1;
        PCSource = 2'b11;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: two instances
// (MEM_LATENCY 1 and 3), CPI table, corner sequences, random model.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       ill;
  } out_t;

  typedef struct {
    logic [3:0] st;
    bit         last;
  } step_t;

  typedef struct {
    int         idx;
    logic [5:0] opc;
    logic       z;
    int         cpi;
    bit         ill;
  } vec_t;

  localparam logic [3:0] T_FETCH  = 4'd0;
  localparam logic [3:0] T_DECODE = 4'd1;
  localparam logic [3:0] T_BRANCH = 4'd10;

`ifdef MULTICYCLE_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic [5:0] op    [2];
  logic       zero  [2];
  logic       pcw   [2];
  logic       iord  [2];
  logic       mrd   [2];
  logic       mwr   [2];
  logic       irw   [2];
  logic       rdst  [2];
  logic       m2r   [2];
  logic       rw    [2];
  logic       srca  [2];
  logic [1:0] srcb  [2];
  logic [1:0] pcsrc [2];
  logic [2:0] aluop [2];
  logic [3:0] st    [2];
  logic       ill   [2];
  out_t       o     [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      multicycle_control #(
        .MEM_LATENCY(g == 0 ? 1 : 3),
        .ALUOP_W    (3)
      ) u_dut (
        .clk     (clk),
        .reset   (rst[g]),
        .OP      (op[g]),
        .zero    (zero[g]),
        .PCWrite (pcw[g]),
        .IorD    (iord[g]),
        .MemRead (mrd[g]),
        .MemWrite(mwr[g]),
        .IRWrite (irw[g]),
        .RegDst  (rdst[g]),
        .MemtoReg(m2r[g]),
        .RegWrite(rw[g]),
        .ALUSrcA (srca[g]),
        .ALUSrcB (srcb[g]),
        .PCSource(pcsrc[g]),
        .ALUOp   (aluop[g]),
        .state_o (st[g]),
        .illegal (ill[g])
      );
      assign o[g] = {st[g], pcw[g], iord[g], mrd[g],
                     mwr[g], irw[g], rdst[g], m2r[g],
                     rw[g], srca[g], srcb[g], pcsrc[g],
                     aluop[g], ill[g]};
    end
  endgenerate

  int    errors = 0;
  int    checks = 0;
  bit    mill [2];
  step_t seq [$];
  vec_t  tbl [$];

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input int idx, input string name,
                         input out_t e, input out_t c);
    checks++;
    if (((o[idx] ^ e) & c) != '0) begin
      errors++;
      $display("FAIL %s inst%0d got=%h want=%h care=%h",
               name, idx, o[idx], e, c);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] x);
    case (x)
      6'h00, 6'h08, 6'h0D, 6'h0C, 6'h23, 6'h2B,
      6'h04, 6'h05, 6'h02: return 1'b1;
      6'h03: return JAL_EN;
      default: return 1'b0;
    endcase
  endfunction

  // Expected instruction trace: list of states visited, cycle by cycle.
  task automatic build(input int lat, input logic [5:0] x);
    seq.delete();
    for (int i = 0; i < lat; i++)
      seq.push_back('{T_FETCH, i == lat - 1});
    seq.push_back('{T_DECODE, 1'b0});
    case (x)
      6'h00: begin
        seq.push_back('{4'd6, 1'b0});
        seq.push_back('{4'd7, 1'b0});
      end
      6'h08, 6'h0D, 6'h0C: begin
        seq.push_back('{4'd8, 1'b0});
        seq.push_back('{4'd9, 1'b0});
      end
      6'h23: begin
        seq.push_back('{4'd2, 1'b0});
        for (int i = 0; i < lat; i++)
          seq.push_back('{4'd3, 1'b0});
        seq.push_back('{4'd4, 1'b0});
      end
      6'h2B: begin
        seq.push_back('{4'd2, 1'b0});
        for (int i = 0; i < lat; i++)
          seq.push_back('{4'd5, 1'b0});
      end
      6'h04, 6'h05: seq.push_back('{T_BRANCH, 1'b0});
      6'h02: seq.push_back('{4'd11, 1'b0});
      6'h03: if (JAL_EN) seq.push_back('{4'd12, 1'b0});
      default: ;
    endcase
  endtask

  task automatic exp_for(input logic [3:0] s,
                         input logic [5:0] x,
                         input logic z, input bit last,
                         input bit il,
                         output out_t e, output out_t c);
    e = '0;
    c = '0;
    c.st = '1; c.pcw = 1; c.mrd = 1; c.mwr = 1;
    c.irw = 1; c.rw = 1; c.ill = 1;
    e.st = s;
    e.ill = il;
    case (s)
      4'd0: begin
        e.mrd = 1; c.iord = 1; c.srca = 1;
        e.srcb = 2'b01; c.srcb = '1;
        e.aluop = 3'b100; c.aluop = '1;
        c.pcsrc = '1;
        e.irw = last; e.pcw = last;
      end
      4'd1: begin
        c.srca = 1; e.srcb = 2'b11; c.srcb = '1;
        e.aluop = 3'b100; c.aluop = '1;
      end
      4'd2: begin
        e.srca = 1; c.srca = 1;
        e.srcb = 2'b10; c.srcb = '1;
        e.aluop = 3'b100; c.aluop = '1;
      end
      4'd3: begin
        e.iord = 1; c.iord = 1; e.mrd = 1;
      end
      4'd4: begin
        c.rdst = 1; e.m2r = 1; c.m2r = 1; e.rw = 1;
      end
      4'd5: begin
        e.iord = 1; c.iord = 1; e.mwr = 1;
      end
      4'd6: begin
        e.srca = 1; c.srca = 1; c.srcb = '1;
        e.aluop = 3'b111; c.aluop = '1;
      end
      4'd7: begin
        e.rdst = 1; c.rdst = 1; c.m2r = 1; e.rw = 1;
      end
      4'd8: begin
        e.srca = 1; c.srca = 1;
        e.srcb = 2'b10; c.srcb = '1;
        c.aluop = '1;
        e.aluop = (x == 6'h0D) ? 3'b101 :
                  (x == 6'h0C) ? 3'b110 : 3'b100;
      end
      4'd9: begin
        c.rdst = 1; e.rw = 1;
      end
      4'd10: begin
        e.srca = 1; c.srca = 1; c.srcb = '1;
        e.aluop = 3'b001; c.aluop = '1;
        e.pcsrc = 2'b01; c.pcsrc = '1;
        e.pcw = (x == 6'h04) ? z : ~z;
      end
      4'd11: begin
        e.pcsrc = 2'b10; c.pcsrc = '1; e.pcw = 1;
      end
      4'd12: begin
        e.rdst = 1; c.rdst = 1; c.m2r = 1;
        c.srca = 1; c.srcb = '1;
        e.aluop = 3'b100; c.aluop = '1;
        e.pcsrc = 2'b10; c.pcsrc = '1;
        e.pcw = 1; e.rw = 1;
      end
      default: ;
    endcase
  endtask

  // Entry/exit point: 1 time unit after a rising edge, DUT in FETCH.
  task automatic run_instr(input int idx,
                           input logic [5:0] x,
                           input logic z);
    out_t e;
    out_t c;
    build(idx == 0 ? 1 : 3, x);
    foreach (seq[k]) begin
      op[idx] = (seq[k].st == T_DECODE) ? x
                                         : 6'($urandom);
      zero[idx] = (seq[k].st == T_BRANCH) ? z
                                           : 1'($urandom);
      exp_for(seq[k].st, x, z, seq[k].last, mill[idx],
              e, c);
      @(negedge clk);
      chk_out(idx, "trace", e, c);
      if (seq[k].st == T_DECODE && !is_legal(x))
        mill[idx] = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_cpi(input int idx, output int n);
    n = 0;
    while (st[idx] == T_FETCH && n < 64) begin
      @(posedge clk); #1; n++;
    end
    while (st[idx] != T_FETCH && n < 64) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    out_t e;
    out_t c;
    int   n;
    int   cur;
    logic [5:0] pick [10];

    rst[0] = 1; rst[1] = 1;
    op[0] = 0; op[1] = 0;
    zero[0] = 0; zero[1] = 0;
    #2;
    rst[0] = 0; rst[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_for(T_FETCH, 0, 0, 1'b1, 1'b0, e, c);
    chk_out(0, "reset_state", e, c);
    exp_for(T_FETCH, 0, 0, 1'b0, 1'b0, e, c);
    chk_out(1, "reset_state", e, c);
    rst[0] = 1;
    mill[0] = 0; mill[1] = 0;

    tbl.push_back('{0, 6'h00, 1'b0, 4, 1'b0});
    tbl.push_back('{0, 6'h23, 1'b0, 5, 1'b0});
    tbl.push_back('{0, 6'h2B, 1'b0, 4, 1'b0});
    tbl.push_back('{0, 6'h04, 1'b1, 3, 1'b0});
    tbl.push_back('{0, 6'h05, 1'b0, 3, 1'b0});
    tbl.push_back('{0, 6'h02, 1'b0, 3, 1'b0});
    tbl.push_back('{0, 6'h08, 1'b0, 4, 1'b0});
    tbl.push_back('{0, 6'h0D, 1'b0, 4, 1'b0});
    tbl.push_back('{0, 6'h0C, 1'b0, 4, 1'b0});
    tbl.push_back('{0, 6'h3F, 1'b0, 2, 1'b1});
    tbl.push_back('{0, 6'h00, 1'b0, 4, 1'b1});
    tbl.push_back('{1, 6'h00, 1'b0, 6, 1'b0});
    tbl.push_back('{1, 6'h23, 1'b0, 9, 1'b0});
    tbl.push_back('{1, 6'h2B, 1'b0, 8, 1'b0});
    tbl.push_back('{1, 6'h04, 1'b0, 5, 1'b0});
    tbl.push_back('{1, 6'h03, 1'b0, JAL_EN ? 5 : 4,
                    !JAL_EN});

    cur = 0;
    foreach (tbl[i]) begin
      if (tbl[i].idx != cur) begin
        rst[cur] = 0;
        rst[tbl[i].idx] = 1;
        cur = tbl[i].idx;
      end
      op[cur] = tbl[i].opc;
      zero[cur] = tbl[i].z;
      count_cpi(cur, n);
      chk($sformatf("cpi_op%h_i%0d", tbl[i].opc, cur),
          n, tbl[i].cpi);
      chk($sformatf("ill_op%h_i%0d", tbl[i].opc, cur),
          int'(ill[cur]), int'(tbl[i].ill));
    end

    // Corner sequences on the latency-1 instance.
    rst[1] = 0;
    rst[0] = 0;
    @(posedge clk); #1;
    rst[0] = 1;
    mill[0] = 0;
    run_instr(0, 6'h3F, 1'b0);
    run_instr(0, 6'h00, 1'b0);
    run_instr(0, 6'h08, 1'b0);
    op[0] = 6'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_exec_r_state", int'(st[0]), 6);
    #2;
    rst[0] = 0;
    #1;
    chk("async_rst_state", int'(st[0]), 0);
    chk("async_rst_memread", int'(mrd[0]), 1);
    chk("async_rst_illegal", int'(ill[0]), 0);
    @(posedge clk); #1;
    rst[0] = 1;
    mill[0] = 0;
    run_instr(0, 6'h00, 1'b0);
    run_instr(0, 6'h04, 1'b1);
    run_instr(0, 6'h05, 1'b1);
    run_instr(0, 6'h04, 1'b0);
    run_instr(0, 6'h03, 1'b0);

    pick = '{6'h00, 6'h08, 6'h0D, 6'h0C, 6'h23,
             6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 10);
      run_instr(0, r == 10 ? 6'($urandom) : pick[r],
                1'($urandom));
    end

    rst[0] = 0;
    rst[1] = 1;
    mill[1] = 0;
    run_instr(1, 6'h23, 1'b0);
    run_instr(1, 6'h2B, 1'b0);
    for (int i = 0; i < 25; i++) begin
      int r;
      r = $urandom_range(0, 10);
      run_instr(1, r == 10 ? 6'($urandom) : pick[r],
                1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
